mcpu_ctrl_fsm: RTL and testbench
================================

// Module: mcpu_ctrl_fsm
// PURPOSE
//  Multi-cycle CPU control sequencer. Decodes opcode/funct from the instruction register and steps each
//  instruction through IF/ID/EX/MEM/WB states. Drives every datapath enable, including PC_Write_Final
//  into the PC register (reset vector 0x0000_3000, owned by the PC). Sits beside the datapath; one instance per core.
// PARAMETERS
//  MEM_WAIT_EN  1  1: MEM/IF states hold until mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk            in   1  core clock, all state on rising edge
//  rst            in   1  synchronous, active-high reset
//  Op             in   6  IR[31:26]
//  Funct          in   6  IR[5:0]
//  Zero           in   1  ALU zero flag (valid in BR state)
//  mem_ready      in   1  memory access complete this cycle
//  PC_Write_Final out  1  PC load enable = PCWrite | (PCWriteCond & Zero)
//  IR_Write       out  1  latch instruction
//  IorD           out  1  0: PC addresses memory, 1: ALUOut
//  Mem_Read       out  1  memory read strobe
//  Mem_Write      out  1  memory write strobe
//  RegWrite       out  1  register file write enable
//  RegDst         out  2  0 rt, 1 rd, 2 $31
//  MemtoReg       out  2  0 ALUOut, 1 MDR, 2 PC
//  ALUSrcA        out  1  0 PC, 1 rs
//  ALUSrcB        out  2  0 rt, 1 const 4, 2 sign-ext imm, 3 imm<<2
//  ALUOp          out  3  0 add, 1 sub, 2 R-type (funct), 3 or, 4 slt
//  PCSource       out  2  0 ALU result, 1 ALUOut, 2 jump target
//  illegal_op     out  1  one-cycle pulse on unsupported opcode/funct
//  state_o        out  4  current state (debug)
// BEHAVIOUR
//  - Moore FSM, all outputs decoded from state (PC_Write_Final also uses Zero, combinational).
//  - rst=1 at edge -> state IF; in-flight instruction abandoned, no write strobes issued.
//    While in reset all enables/strobes = 0, other outputs 0.
//  - States: IF(0) ID(1) MA(2) MR(3) MWB(4) MW(5) EXR(6) WBR(7) BR(8) JMP(9) EXI(10) WBI(11) JAL(12).
//  - IF: Mem_Read, IR_Write, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0, PCWrite.
//    IR_Write/PCWrite asserted only in the cycle mem_ready=1; otherwise stay IF (PC unchanged).
//  - ID: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target). Next by Op:
//    lw/sw->MA, R-type->EXR, beq->BR, j->JMP, jal->JAL, addi/ori/slti->EXI, else->IF + illegal_op.
//  - R-type funct legal set: add,sub,and,or,slt,sll,srl,jr; others -> IF + illegal_op, no write.
//    jr: EXR asserts PCWrite with PCSource=0, ALUSrcA=1, ALUOp=add, ALUSrcB=0 with rt ignored (rs+0); next IF.
//  - MA: ALUSrcA=1, ALUSrcB=2, add. lw->MR, sw->MW.
//  - MR: Mem_Read, IorD=1; hold until mem_ready, then MWB. MWB: RegWrite, RegDst=0, MemtoReg=1 -> IF.
//  - MW: Mem_Write, IorD=1; hold until mem_ready -> IF. Mem_Write held stable for whole wait.
//  - EXR: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> WBR: RegWrite, RegDst=1, MemtoReg=0 -> IF.
//  - BR: ALUSrcA=1, ALUSrcB=0, sub, PCWriteCond, PCSource=1 -> IF. Taken iff Zero=1 in BR.
//  - JMP: PCWrite, PCSource=2 -> IF. JAL: PCWrite, PCSource=2, RegWrite, RegDst=2, MemtoReg=2 -> IF.
//  - EXI: ALUSrcA=1, ALUSrcB=2, ALUOp add/or/slt per Op -> WBI: RegWrite, RegDst=0, MemtoReg=0 -> IF.
//  - Latency (mem_ready=1): R 4, lw 5, sw 4, beq 3, j/jal 3, imm 4 cycles. Each mem wait adds 1.
//  - Unreachable state encodings (13-15) -> IF next cycle, all outputs 0.
//  - MEM_WAIT_EN=0: all holds bypassed, fixed latencies above.
// STRUCTURE
//  - Shared package mcpu_pkg: state encodings, opcode/funct constants, ALUOp/PCSource/RegDst enums.
//  - One sub-module: mcpu_ctrl_decode (combinational Op/Funct -> instruction class + legal flag).
//  - FSM next-state and output decode stay in this module.
// TESTING
//  - rst held 2 cycles mid-MW wait -> next cycle state IF, Mem_Write=0, no PC_Write_Final pulse.
//  - add $3,$1,$2 (Op 0, Funct 0x20), mem_ready=1 -> states 0,1,6,7; RegWrite=1, RegDst=1 only in WBR.
//  - lw with mem_ready low 3 cycles in MR -> MR held 4 cycles, Mem_Read/IorD=1 steady, then MWB, RegWrite 1 cycle.
//  - beq, Zero=1 -> PC_Write_Final=1, PCSource=1 in BR; repeat Zero=0 -> PC_Write_Final=0.
//  - jal (Op 0x03) -> JAL: PC_Write_Final=1, PCSource=2, RegDst=2, MemtoReg=2, RegWrite=1.
//  - Op 0x3F -> ID then IF, illegal_op pulses exactly 1 cycle, no RegWrite/Mem_Write/PC write.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
// State encodings, instruction classes, opcode/funct values and datapath select enums.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_MWB = 4'd4,
    S_MW  = 4'd5,
    S_EXR = 4'd6,
    S_WBR = 4'd7,
    S_BR  = 4'd8,
    S_JMP = 4'd9,
    S_EXI = 4'd10,
    S_WBI = 4'd11,
    S_JAL = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL  = 4'd0,
    CL_R    = 4'd1,
    CL_JR   = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BEQ  = 4'd5,
    CL_J    = 4'd6,
    CL_JAL  = 4'd7,
    CL_ADDI = 4'd8,
    CL_ORI  = 4'd9,
    CL_SLTI = 4'd10
  } iclass_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_RTYPE = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4
  } aluop_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2
  } pcsrc_t;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'd0,
    M2R_MDR    = 2'd1,
    M2R_PC     = 2'd2
  } memtoreg_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef struct packed {
    logic      ir_write;
    logic      pc_write;
    logic      pc_write_cond;
    logic      iord;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    regdst_t   reg_dst;
    memtoreg_t mem_to_reg;
    logic      alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t    alu_op;
    pcsrc_t    pc_source;
  } ctrl_t;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational instruction classifier: maps Op/Funct to an instruction class.
// Anything outside the supported set, including unsupported R-type functs, is CL_ILL.
module mcpu_ctrl_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class,
  output logic       o_legal
);

  iclass_t w_class;

  always_comb begin
    w_class = CL_ILL;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          F_JR:                                       w_class = CL_JR;
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: w_class = CL_R;
          default:                                    w_class = CL_ILL;
        endcase
      end
      OP_LW:   w_class = CL_LW;
      OP_SW:   w_class = CL_SW;
      OP_BEQ:  w_class = CL_BEQ;
      OP_J:    w_class = CL_J;
      OP_JAL:  w_class = CL_JAL;
      OP_ADDI: w_class = CL_ADDI;
      OP_ORI:  w_class = CL_ORI;
      OP_SLTI: w_class = CL_SLTI;
      default: w_class = CL_ILL;
    endcase
  end

  assign o_class = w_class;
  assign o_legal = (w_class != CL_ILL);

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: steps each instruction through IF/ID/EX/MEM/WB
// and drives every datapath enable, including the final PC load enable.
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PC_Write_Final,
  output logic       IR_Write,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  logic [3:0] w_class_raw;
  iclass_t    w_class;
  logic       w_legal;
  logic       w_ready;
  logic       w_live;
  logic       w_pc_write;
  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic       r_illegal;

  mcpu_ctrl_decode u_decode (
    .i_op    (Op),
    .i_funct (Funct),
    .o_class (w_class_raw),
    .o_legal (w_legal)
  );

  assign w_class = iclass_t'(w_class_raw);
  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  function automatic ctrl_t ctrl_of(state_t s, iclass_t c);
    ctrl_t o;
    o = '0;
    case (s)
      S_IF: begin
        o.mem_read  = 1'b1;
        o.ir_write  = 1'b1;
        o.pc_write  = 1'b1;
        o.alu_src_b = 2'd1;
      end
      S_ID:  o.alu_src_b = 2'd3;
      S_MA: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd2;
      end
      S_MR: begin
        o.mem_read = 1'b1;
        o.iord     = 1'b1;
      end
      S_MWB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = M2R_MDR;
      end
      S_MW: begin
        o.mem_write = 1'b1;
        o.iord      = 1'b1;
      end
      S_EXR: begin
        o.alu_src_a = 1'b1;
        if (c == CL_JR) o.pc_write = 1'b1;
        else            o.alu_op   = ALU_RTYPE;
      end
      S_WBR: begin
        o.reg_write = 1'b1;
        o.reg_dst   = RD_RD;
      end
      S_BR: begin
        o.alu_src_a     = 1'b1;
        o.alu_op        = ALU_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_source     = PCS_ALUOUT;
      end
      S_JMP: begin
        o.pc_write  = 1'b1;
        o.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        o.pc_write   = 1'b1;
        o.pc_source  = PCS_JUMP;
        o.reg_write  = 1'b1;
        o.reg_dst    = RD_RA;
        o.mem_to_reg = M2R_PC;
      end
      S_EXI: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd2;
        o.alu_op    = (c == CL_ORI) ? ALU_OR : (c == CL_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_WBI: o.reg_write = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = w_ready ? S_ID : S_IF;
      S_ID: begin
        case (w_class)
          CL_LW, CL_SW:              w_next = S_MA;
          CL_R, CL_JR:               w_next = S_EXR;
          CL_BEQ:                    w_next = S_BR;
          CL_J:                      w_next = S_JMP;
          CL_JAL:                    w_next = S_JAL;
          CL_ADDI, CL_ORI, CL_SLTI:  w_next = S_EXI;
          default:                   w_next = S_IF;
        endcase
      end
      S_MA:  w_next = (w_class == CL_LW) ? S_MR : S_MW;
      S_MR:  w_next = w_ready ? S_MWB : S_MR;
      S_MWB: w_next = S_IF;
      S_MW:  w_next = w_ready ? S_IF : S_MW;
      S_EXR: w_next = (w_class == CL_JR) ? S_IF : S_WBR;
      S_EXI: w_next = S_WBI;
      default: w_next = S_IF;
    endcase
  end

  // Outputs are registered from the next state, so they always match r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IF;
      r_ctrl    <= ctrl_of(S_IF, CL_ILL);
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= ctrl_of(w_next, w_class);
      r_illegal <= (r_state == S_ID) && !w_legal;
    end
  end

  // Reset and stray encodings blank everything; fetch enables wait on memory.
  assign w_live     = !rst && (r_state <= S_JAL);
  assign w_pc_write = r_ctrl.pc_write && ((r_state != S_IF) || w_ready);

  assign PC_Write_Final = w_live && (w_pc_write || (r_ctrl.pc_write_cond && Zero));
  assign IR_Write       = w_live && r_ctrl.ir_write && w_ready;
  assign IorD           = w_live && r_ctrl.iord;
  assign Mem_Read       = w_live && r_ctrl.mem_read;
  assign Mem_Write      = w_live && r_ctrl.mem_write;
  assign RegWrite       = w_live && r_ctrl.reg_write;
  assign RegDst         = w_live ? r_ctrl.reg_dst    : '0;
  assign MemtoReg       = w_live ? r_ctrl.mem_to_reg : '0;
  assign ALUSrcA        = w_live && r_ctrl.alu_src_a;
  assign ALUSrcB        = w_live ? r_ctrl.alu_src_b  : '0;
  assign ALUOp          = w_live ? r_ctrl.alu_op     : '0;
  assign PCSource       = w_live ? r_ctrl.pc_source  : '0;
  assign illegal_op     = !rst && r_illegal;
  assign state_o        = r_state;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed self-checking bench for the multi-cycle control sequencer.
module tb_mcpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PC_Write_Final, IR_Write, IorD, Mem_Read, Mem_Write, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic       ALUSrcA, illegal_op;
  logic [2:0] ALUOp;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  mcpu_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PC_Write_Final(PC_Write_Final), .IR_Write(IR_Write), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
    adv(); adv();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_o); end
    checks++; if (Mem_Read !== 1'b0) begin errors++; $display("FAIL rst_memread: got %b want 0", Mem_Read); end
    checks++; if (PC_Write_Final !== 1'b0) begin errors++; $display("FAIL rst_pcw: got %b want 0", PC_Write_Final); end
    checks++; if (IR_Write !== 1'b0) begin errors++; $display("FAIL rst_irw: got %b want 0", IR_Write); end
    checks++; if (ALUSrcB !== 2'd0) begin errors++; $display("FAIL rst_srcb: got %0d want 0", ALUSrcB); end
    rst = 1'b0;
    #1;
    checks++; if (Mem_Read !== 1'b1) begin errors++; $display("FAIL if_memread: got %b want 1", Mem_Read); end
    checks++; if (IR_Write !== 1'b1) begin errors++; $display("FAIL if_irw: got %b want 1", IR_Write); end
    checks++; if (PC_Write_Final !== 1'b1) begin errors++; $display("FAIL if_pcw: got %b want 1", PC_Write_Final); end
    checks++; if (ALUSrcB !== 2'd1) begin errors++; $display("FAIL if_srcb: got %0d want 1", ALUSrcB); end
  endtask

  task automatic test_rtype();
    int exp_st [4] = '{0, 1, 6, 7};
    Op = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state_o !== 4'(exp_st[i])) begin errors++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]); end
      checks++; if (RegWrite !== (i == 3)) begin errors++; $display("FAIL add_regwrite[%0d]: got %b want %b", i, RegWrite, (i == 3)); end
      checks++; if (RegDst !== ((i == 3) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL add_regdst[%0d]: got %0d", i, RegDst); end
      if (i == 2) begin
        checks++; if (ALUOp !== 3'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'd0) begin
          errors++; $display("FAIL add_exr_alu: got op=%0d a=%b b=%0d want 2/1/0", ALUOp, ALUSrcA, ALUSrcB);
        end
      end
      adv();
    end
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL add_done: got %0d want 0", state_o); end
  endtask

  task automatic test_lw_wait();
    Op = 6'h23; Funct = 6'h00; mem_ready = 1'b1;
    #1;
    adv(); adv();
    checks++; if (state_o !== 4'd2 || ALUSrcB !== 2'd2) begin errors++; $display("FAIL lw_ma: got st=%0d b=%0d want 2/2", state_o, ALUSrcB); end
    adv();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++; if (state_o !== 4'd3) begin errors++; $display("FAIL lw_mr_state[%0d]: got %0d want 3", i, state_o); end
      checks++; if (Mem_Read !== 1'b1 || IorD !== 1'b1) begin errors++; $display("FAIL lw_mr_strobe[%0d]: got rd=%b iord=%b want 1/1", i, Mem_Read, IorD); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL lw_mr_rw[%0d]: got %b want 0", i, RegWrite); end
      adv();
    end
    checks++; if (state_o !== 4'd4 || RegWrite !== 1'b1 || MemtoReg !== 2'd1 || RegDst !== 2'd0) begin
      errors++; $display("FAIL lw_mwb: got st=%0d rw=%b m2r=%0d rd=%0d want 4/1/1/0", state_o, RegWrite, MemtoReg, RegDst);
    end
    adv();
    checks++; if (state_o !== 4'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL lw_done: got st=%0d rw=%b want 0/0", state_o, RegWrite); end
  endtask

  task automatic test_reset_mid_write();
    Op = 6'h2B; mem_ready = 1'b1;
    #1;
    adv(); adv();
    mem_ready = 1'b0;
    adv();
    checks++; if (state_o !== 4'd5 || Mem_Write !== 1'b1 || IorD !== 1'b1) begin
      errors++; $display("FAIL sw_mw: got st=%0d wr=%b iord=%b want 5/1/1", state_o, Mem_Write, IorD);
    end
    adv();
    checks++; if (state_o !== 4'd5 || Mem_Write !== 1'b1) begin errors++; $display("FAIL sw_mw_hold: got st=%0d wr=%b want 5/1", state_o, Mem_Write); end
    rst = 1'b1;
    #1;
    checks++; if (Mem_Write !== 1'b0) begin errors++; $display("FAIL rstmw_wr: got %b want 0", Mem_Write); end
    for (int i = 0; i < 2; i++) begin
      adv();
      checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rstmw_state[%0d]: got %0d want 0", i, state_o); end
      checks++; if (Mem_Write !== 1'b0 || PC_Write_Final !== 1'b0) begin
        errors++; $display("FAIL rstmw_strobe[%0d]: got wr=%b pcw=%b want 0/0", i, Mem_Write, PC_Write_Final);
      end
    end
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'd0 || Mem_Read !== 1'b1 || IR_Write !== 1'b0 || PC_Write_Final !== 1'b0 || Mem_Write !== 1'b0) begin
      errors++; $display("FAIL rstmw_ifwait: got st=%0d rd=%b irw=%b pcw=%b wr=%b want 0/1/0/0/0", state_o, Mem_Read, IR_Write, PC_Write_Final, Mem_Write);
    end
    adv();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rstmw_ifhold: got %0d want 0", state_o); end
    mem_ready = 1'b1;
    #1;
    checks++; if (PC_Write_Final !== 1'b1 || IR_Write !== 1'b1) begin errors++; $display("FAIL rstmw_fetch: got pcw=%b irw=%b want 1/1", PC_Write_Final, IR_Write); end
  endtask

  task automatic test_beq();
    Op = 6'h04; Zero = 1'b0; mem_ready = 1'b1;
    #1;
    adv();
    Zero = 1'b1;
    #1;
    checks++; if (state_o !== 4'd1 || PC_Write_Final !== 1'b0) begin errors++; $display("FAIL beq_id: got st=%0d pcw=%b want 1/0", state_o, PC_Write_Final); end
    adv();
    checks++; if (state_o !== 4'd8 || PC_Write_Final !== 1'b1 || PCSource !== 2'd1 || ALUOp !== 3'd1) begin
      errors++; $display("FAIL beq_taken: got st=%0d pcw=%b src=%0d op=%0d want 8/1/1/1", state_o, PC_Write_Final, PCSource, ALUOp);
    end
    Zero = 1'b0;
    adv();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL beq_lat: got %0d want 0", state_o); end
    adv(); adv();
    checks++; if (state_o !== 4'd8 || PC_Write_Final !== 1'b0 || PCSource !== 2'd1) begin
      errors++; $display("FAIL beq_nottaken: got st=%0d pcw=%b src=%0d want 8/0/1", state_o, PC_Write_Final, PCSource);
    end
    adv();
  endtask

  task automatic test_jal();
    Op = 6'h03; mem_ready = 1'b1;
    #1;
    adv();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL jal_id: got %0d want 1", state_o); end
    adv();
    checks++; if (state_o !== 4'd12 || PC_Write_Final !== 1'b1 || PCSource !== 2'd2) begin
      errors++; $display("FAIL jal_pc: got st=%0d pcw=%b src=%0d want 12/1/2", state_o, PC_Write_Final, PCSource);
    end
    checks++; if (RegDst !== 2'd2 || MemtoReg !== 2'd2 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL jal_wb: got rd=%0d m2r=%0d rw=%b want 2/2/1", RegDst, MemtoReg, RegWrite);
    end
    adv();
    checks++; if (state_o !== 4'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL jal_done: got st=%0d rw=%b want 0/0", state_o, RegWrite); end
  endtask

  task automatic test_illegal();
    Op = 6'h3F; Funct = 6'h00; mem_ready = 1'b1;
    #1;
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_if: got %b want 0", illegal_op); end
    adv();
    checks++; if (state_o !== 4'd1 || illegal_op !== 1'b0 || PC_Write_Final !== 1'b0 || RegWrite !== 1'b0 || Mem_Write !== 1'b0) begin
      errors++; $display("FAIL ill_id: got st=%0d ill=%b pcw=%b rw=%b wr=%b want 1/0/0/0/0", state_o, illegal_op, PC_Write_Final, RegWrite, Mem_Write);
    end
    mem_ready = 1'b0;
    adv();
    checks++; if (state_o !== 4'd0 || illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse: got st=%0d ill=%b want 0/1", state_o, illegal_op); end
    checks++; if (PC_Write_Final !== 1'b0 || RegWrite !== 1'b0 || Mem_Write !== 1'b0) begin
      errors++; $display("FAIL ill_nowrite: got pcw=%b rw=%b wr=%b want 0/0/0", PC_Write_Final, RegWrite, Mem_Write);
    end
    adv();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_width: got %b want 0", illegal_op); end
    Op = 6'h00; Funct = 6'h3F; mem_ready = 1'b1;
    #1;
    adv();
    mem_ready = 1'b0;
    adv();
    checks++; if (state_o !== 4'd0 || illegal_op !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL illfn: got st=%0d ill=%b rw=%b want 0/1/0", state_o, illegal_op, RegWrite);
    end
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    Op = 6'h00; Funct = 6'h08; mem_ready = 1'b1;
    #1;
    adv(); adv();
    checks++; if (state_o !== 4'd6 || PC_Write_Final !== 1'b1 || PCSource !== 2'd0) begin
      errors++; $display("FAIL jr_pc: got st=%0d pcw=%b src=%0d want 6/1/0", state_o, PC_Write_Final, PCSource);
    end
    checks++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'd0 || ALUOp !== 3'd0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL jr_alu: got a=%b b=%0d op=%0d rw=%b want 1/0/0/0", ALUSrcA, ALUSrcB, ALUOp, RegWrite);
    end
    adv();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL jr_lat: got %0d want 0", state_o); end
    Op = 6'h0D;
    #1;
    adv(); adv();
    checks++; if (state_o !== 4'd10 || ALUOp !== 3'd3 || ALUSrcB !== 2'd2 || ALUSrcA !== 1'b1) begin
      errors++; $display("FAIL ori_exi: got st=%0d op=%0d b=%0d a=%b want 10/3/2/1", state_o, ALUOp, ALUSrcB, ALUSrcA);
    end
    adv();
    checks++; if (state_o !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 2'd0 || MemtoReg !== 2'd0) begin
      errors++; $display("FAIL ori_wbi: got st=%0d rw=%b rd=%0d m2r=%0d want 11/1/0/0", state_o, RegWrite, RegDst, MemtoReg);
    end
    adv();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL ori_lat: got %0d want 0", state_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_reset_mid_write();
    test_beq();
    test_jal();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
